// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer sitting directly downstream of the 16-bit CLA
// incrementer. It holds the current PC and drives it onto the incrementer
// input (carry-in is tied to 1 outside this block). It takes the
// incrementer's PC+1 result back to advance the PC. It offers each PC to the
// fetch stage over a valid/ready handshake.
//
// Ports
//   clk            : single clock, all state changes on the rising edge
//   reset          : synchronous, active-high; overrides every other input
//   incr_a         : current PC, straight from the PC register
//   incr_s         : incrementer sum (PC+1), combinational return path
//   redirect_valid : load redirect_pc into the PC (branch/jump)
//   redirect_pc    : redirect target
//   halt_req       : request to stop fetching
//   resume         : leave HALT (ignored in other states)
//   fetch_valid    : fetch_pc is being offered
//   fetch_pc       : PC offered to the fetch stage
//   fetch_ready    : fetch stage accepts fetch_pc this cycle
//   wrapped        : sticky, set when the PC advances from all-ones to zero
//   fetch_count    : number of accepted fetches, saturating at 16'hFFFF
//   state          : FSM state, IDLE=00 RUN=01 HALT=10
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] incr_a,
    input  logic [WIDTH-1:0] incr_s,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_req,
    input  logic             resume,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_pc,
    input  logic             fetch_ready,
    output logic             wrapped,
    output logic [15:0]      fetch_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t           fsm;
    state_t           fsm_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [15:0]      count;
    logic [15:0]      count_next;
    logic             wrap_flag;
    logic             wrap_next;
    logic             accept;

    // Saturating increment of the accepted-fetch counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

    // The PC register feeds both the incrementer and the fetch stage; there is
    // deliberately no adder here, the only advance path is incr_s.
    assign incr_a      = pc;
    assign fetch_pc    = pc;
    assign fetch_valid = (fsm == RUN) && !redirect_valid;
    assign accept      = fetch_valid && fetch_ready;
    assign wrapped     = wrap_flag;
    assign fetch_count = count;
    assign state       = fsm;

    always_comb begin
        fsm_next   = fsm;
        pc_next    = pc;
        count_next = count;
        wrap_next  = wrap_flag;

        unique case (fsm)
            IDLE: begin
                // One bubble after reset, then start fetching regardless.
                fsm_next = RUN;
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end
            end

            RUN: begin
                // A redirect suppresses fetch_valid, so it can never
                // coincide with an accept.
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end else if (accept) begin
                    pc_next    = incr_s;
                    count_next = sat_inc16(count);
                    if ((pc == '1) && (incr_s == '0)) begin
                        wrap_next = 1'b1;
                    end
                end
                if (halt_req) begin
                    fsm_next = HALT;
                end
            end

            HALT: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end
                // A fresh halt request wins over a simultaneous resume.
                if (resume && !halt_req) begin
                    fsm_next = RUN;
                end
            end

            default: begin
                // Code 11 is unreachable in normal operation; fall back to a
                // clean restart.
                fsm_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            pc        <= RESET_PC;
            count     <= 16'd0;
            wrap_flag <= 1'b0;
        end else begin
            fsm       <= fsm_next;
            pc        <= pc_next;
            count     <= count_next;
            wrap_flag <= wrap_next;
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer that sits directly downstream of the 16-bit CLA incrementer.
- Holds the current PC and drives it to the incrementer input; the incrementer's carry-in is tied to 1.
- Consumes the incrementer's PC+1 result to advance the PC.
- Presents each PC to the fetch stage over a valid/ready handshake, with redirect (branch/jump), halt/resume, a sticky wrap flag and a saturating fetch counter.

Parameters:
- WIDTH, 16: PC width; must match the incrementer width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- incr_a  output  WIDTH  current PC, wired straight from the PC register to the incrementer input.
- incr_s  input  WIDTH  incrementer sum (PC+1), combinational return.
- redirect_valid  input  1  load redirect_pc into the PC.
- redirect_pc  input  WIDTH  redirect target.
- halt_req  input  1  request to stop fetching.
- resume  input  1  leave HALT.
- fetch_valid  output  1  fetch_pc is offered to the fetch stage.
- fetch_pc  output  WIDTH  PC offered to the fetch stage.
- fetch_ready  input  1  fetch stage accepts fetch_pc.
- wrapped  output  1  sticky flag: the PC has advanced from all-ones to zero.
- fetch_count  output  16  number of accepted fetches, saturating.
- state  output  2  FSM state: IDLE=00, RUN=01, HALT=10.

Behaviour:
- Reset (synchronous, overrides every other input including redirect):
  - pc=RESET_PC, state=IDLE, wrapped=0, fetch_count=0.
  - fetch_valid=0 while reset is high and in IDLE.
- Derived signals:
  - incr_a = pc and fetch_pc = pc at all times (combinational).
  - fetch_valid = (state==RUN) & ~redirect_valid.
  - accept = fetch_valid & fetch_ready.
- IDLE: go to RUN on the next cycle unconditionally. This gives one bubble after reset. redirect_valid in IDLE loads the PC.
- RUN, priority redirect > accept; halt_req is evaluated alongside both:
  - redirect_valid: pc <= redirect_pc. No accept occurs (fetch_valid is low), fetch_count is unchanged, and the FSM stays in RUN unless halt_req is also high.
  - accept: pc <= incr_s and fetch_count increments (it holds at 16'hFFFF).
  - If pc is all-ones and incr_s==0 on an accept, wrapped <= 1. wrapped clears only on reset.
  - No accept with fetch_valid=1: pc, fetch_pc and fetch_count hold stable.
  - halt_req: next state is HALT. An accept in the same cycle is honoured (pc advances and the count increments). A redirect in the same cycle also takes effect.
- HALT:
  - fetch_valid=0.
  - redirect_valid loads the PC and the FSM stays in HALT.
  - resume with halt_req low: go to RUN on the next cycle.
  - resume and halt_req both high: stay in HALT.
  - A resume outside HALT is ignored.
- Other rules:
  - Latency: accept in cycle N puts the new PC on fetch_pc in cycle N+1. Redirect behaves the same way.
  - The block does not check incr_s. The PC advances only through incr_s and never through an internal adder.
  - Illegal state code 11 recovers to IDLE on the next cycle.

Test Plan:
1. Reset with RESET_PC=0, reset deasserted, fetch_ready=1 held → one cycle of fetch_valid=0 (IDLE), then fetch_pc = 0,1,2,3 on consecutive cycles. fetch_count=4 after 4 accepts; incr_a tracks fetch_pc.
2. Backpressure: pc=5, fetch_ready=0 for 3 cycles → fetch_valid=1, fetch_pc stays 5, count unchanged. Then ready=1 → fetch_pc=6 on the next cycle.
3. Redirect: pc=7, ready=1, redirect_valid=1 with redirect_pc=16'h1234 → fetch_valid=0 that cycle, count unchanged, next fetch_pc=16'h1234.
4. Wrap: redirect to 16'hFFFF, then accept → fetch_pc=16'h0000 and wrapped=1. wrapped stays 1 across further accepts and redirects until reset.
5. Halt/resume:
   - halt_req with accept at pc=16'h0010 → pc=16'h0011, state=HALT, fetch_valid=0.
   - redirect to 16'h0040 in HALT → state stays HALT.
   - resume → state=RUN, fetch_pc=16'h0040.
6. Reset mid-run, with redirect_valid=1 and fetch_count=16'hFFFF saturated beforehand → pc=RESET_PC, state=IDLE, fetch_count=0, wrapped=0, fetch_valid=0.
